cart_sdram_arbiter: RTL
=======================

Name: cart_sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM port used for cartridge ROM between two requesters: the ROM image loader (ioctl byte writes) and the CPU cartridge read path.
- Sequences one SDRAM transaction at a time with a req/ack handshake.
- Stretches CPU cycles through a wait output, and holds off the loader through ld_wait.
- Keeps a one-entry read cache so repeated CPU reads of the same byte add no wait states. Sits between cart_rom and the SDRAM controller.

Parameters:
ADDR_W, 25, byte address width for both requesters and the SDRAM port.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ld_wr  in  1  loader write strobe, one-cycle pulse
ld_addr  in  ADDR_W  loader byte address, valid with ld_wr
ld_data  in  8  loader write data, valid with ld_wr
ld_wait  out  1  high while a loader write is pending or in flight
cpu_rd  in  1  CPU cartridge read request, level, held for the whole bus cycle
cpu_addr  in  ADDR_W  CPU read byte address, stable while cpu_rd is high
cpu_data  out  8  read data; valid whenever cpu_rd=1 and cpu_wait_n=1
cpu_wait_n  out  1  active-low wait to the Z80 WAIT_n logic
mem_req  out  1  SDRAM request, held high until mem_ack
mem_we  out  1  1=write, 0=read; stable while mem_req is high
mem_addr  out  ADDR_W  SDRAM byte address; stable while mem_req is high
mem_din  out  8  write data to SDRAM
mem_dout  in  8  read data from SDRAM, valid in the mem_ack cycle
mem_ack  in  1  one-cycle completion pulse from the SDRAM controller

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_din=0, ld_wait=0, cpu_data=8'hFF.
  - Cache valid=0. Loader-pending flag=0. FSM=IDLE.
- Reset mid-transaction: mem_req drops on the next edge and the pending operation is discarded. The SDRAM controller is reset by the same signal.
- Hit:
  - hit = cache_valid & (cpu_addr == cache_addr).
  - cpu_wait_n = ~(cpu_rd & ~hit), combinational, so wait asserts in the same cycle a missing read starts.
  - cpu_data = cache_data (registered).
- Loader capture:
  - ld_wr in cycle N sets the pending flag and latches addr/data; ld_wait=1 from N+1.
  - ld_wr while already pending is a protocol violation: ignored, latched values unchanged.
- FSM states:
  - IDLE:
    - If the pending flag is set, go to WRITE with mem_req=1, mem_we=1 (registered, visible N+1).
    - Else if cpu_rd & ~hit, go to READ with mem_req=1, mem_we=0, mem_addr=cpu_addr.
    - Loader has priority when both are present in the same cycle.
  - WRITE: on mem_ack, go to IDLE; mem_req=0, pending=0, ld_wait=0 in the next cycle. If ld_addr matches cache_addr, clear cache_valid.
  - READ: on mem_ack, go to IDLE:
    - cache_addr=mem_addr, cache_data=mem_dout, cache_valid=1.
    - cpu_wait_n rises in the cycle after ack, via hit.
    - If cpu_rd dropped mid-read, the read still completes and fills the cache.
- Latency: a miss costs 1 (request register) + SDRAM latency + 1 (cache update) cycles. A hit costs 0.
- Back-to-back requests: mem_req is low for at least one cycle between transactions (IDLE is always visited).
- cpu_addr change while cpu_rd stays high and not hit: treated as a new miss once back in IDLE.
- A cache hit never issues mem_req.
- mem_ack while in IDLE: ignored.

Test Plan:
- Reset then idle: all outputs hold reset values; cpu_rd=1 at addr 0x00010 gives cpu_wait_n=0 the same cycle and mem_req=1, mem_we=0 the next cycle. Ack with mem_dout=0x3C (3-cycle latency) gives cpu_data=0x3C and cpu_wait_n=1 one cycle after ack.
- Hit: repeat the read of 0x00010 gives cpu_wait_n=1 immediately and no mem_req. A read of 0x00011 is a miss and issues a new request.
- Loader write: ld_wr to 0x00010 with data 0xA5 gives ld_wait=1 next cycle, then mem_req=1, mem_we=1, mem_din=0xA5; after ack, ld_wait=0 and the cache is invalidated, so the next read of 0x00010 misses and returns 0xA5.
- Simultaneous: ld_wr and a missing cpu_rd in the same IDLE cycle: the write is issued first, then the read. cpu_wait_n stays 0 throughout until the read data is cached.
- Abandoned read: cpu_rd is dropped two cycles into READ; the transaction completes and the cache fills. A following cpu_rd to the same address hits with zero wait.
- Reset mid-WRITE: reset asserted while mem_req=1 gives mem_req=0, ld_wait=0, cache invalid on the next edge, and a later ack is ignored.

Source files
------------

// File: rtl/cart_sdram_arbiter.sv
// cart_sdram_arbiter: shares the cartridge-ROM SDRAM byte port between the
// ROM image loader (writes) and the CPU cartridge read path (reads).
// One SDRAM transaction is in flight at a time, using a req/ack handshake.
// A one-entry read cache lets repeated CPU reads of the same byte complete
// with no wait states.
`timescale 1ns/1ps
module cart_sdram_arbiter #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_wait,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_wait_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t              r_state;

  // Loader holding register: one outstanding write at most.
  logic                r_pend;
  logic [ADDR_W-1:0]   r_ld_addr;
  logic [7:0]          r_ld_data;

  // One-entry read cache.
  logic                r_cache_valid;
  logic [ADDR_W-1:0]   r_cache_addr;
  logic [7:0]          r_cache_data;

  // Registered SDRAM request signals.
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_din;

  logic                w_hit;
  logic                w_miss;
  logic                w_ld_go;

  // A hit is resolved combinationally so the CPU sees wait in the same
  // cycle its read misses, and sees it released as soon as the cache fills.
  assign w_hit      = r_cache_valid & (cpu_addr == r_cache_addr);
  assign w_miss     = cpu_rd & ~w_hit;
  // A strobe arriving this cycle counts as pending, so the loader still
  // wins over a CPU miss presented in the same IDLE cycle.
  assign w_ld_go    = r_pend | ld_wr;

  assign cpu_wait_n = ~w_miss;
  assign cpu_data   = r_cache_data;
  assign ld_wait    = r_pend;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;

  // Capture a loader write; strobes that arrive while one is pending are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_ld_addr <= '0;
      r_ld_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      if (ld_wr && !r_pend) begin
        r_pend    <= 1'b1;
        r_ld_addr <= ld_addr;
        r_ld_data <= ld_data;
      end else if (r_state == ST_WRITE && mem_ack) begin
        r_pend    <= 1'b0;
      end
    end
  end

  // Transaction sequencer: launches one access from IDLE, retires it on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_data  <= 8'hFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ld_go) begin
            r_state    <= ST_WRITE;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_pend ? r_ld_addr : ld_addr;
            r_mem_din  <= r_pend ? r_ld_data : ld_data;
          end else if (w_miss) begin
            r_state    <= ST_READ;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= cpu_addr;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            // The cached byte is now stale if the loader overwrote it.
            if (r_cache_valid && (r_cache_addr == r_mem_addr)) begin
              r_cache_valid <= 1'b0;
            end
          end
        end
        ST_READ: begin
          // The fill happens even if the CPU has abandoned the read.
          if (mem_ack) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_mem_addr;
            r_cache_data  <= mem_dout;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
